sdi_key_loader: RTL and testbench

- Receiving end of the secret-data-input (SDI) key-loading protocol inside the LWC core.
- Accepts the LDKEY instruction, the KEY segment header and the key payload words over a valid/ready bus.
- Assembles the key into a shadow register and commits it atomically to the cipher datapath's key register.
- Sits between the SDI port and the Romulus tweakey/key-schedule logic; ACTKEY on PDI is handled elsewhere.

---
 rtl/romulus_config_pkg.sv | 19 +
 rtl/sdi_word_counter.sv | 35 +++
 rtl/sdi_key_loader.sv | 209 ++++++++++++++++++++
 tb/tb_sdi_key_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_config_pkg.sv
// Shared constants for the Romulus LWC core: SDI/PDI opcodes, segment
// types, default bus width and the SDI key-loader state encodings.
package romulus_config_pkg;

    localparam int BUSW = 32;

    localparam logic [3:0] LDKEY  = 4'b0100;
    localparam logic [3:0] ACTKEY = 4'b0111;
    localparam logic [3:0] KEY    = 4'b1100;

    typedef enum logic [2:0] {
        INSTR,
        HDR,
        DATA,
        COMMIT,
        DRAIN
    } loader_state_t;

endpackage

// File: rtl/sdi_word_counter.sv
// Loadable down-counter of bus words. The load value is a byte length,
// rounded up to whole BUSW-wide words. "last" flags the final word.
module sdi_word_counter #(
    parameter int BUSW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_bytes,
    input  logic        dec,
    output logic        last
);

    localparam int SHIFT = $clog2(BUSW / 8);

    logic [15:0] count_reg;
    logic [16:0] rounded;

    // Round the byte length up to a whole number of words.
    assign rounded = {1'b0, load_bytes} + 17'(BUSW / 8 - 1);

    // Count register: load has priority over decrement, never wraps below 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= 16'(rounded >> SHIFT);
        end else if (dec && (count_reg != 16'd0)) begin
            count_reg <= count_reg - 16'd1;
        end
    end

    assign last = (count_reg == 16'd1);

endmodule

// File: rtl/sdi_key_loader.sv
// SDI key loader: parses LDKEY + KEY header + key words from the SDI bus,
// assembles the key in a shadow register and commits it atomically to
// key_out (deferred while key_lock is high).
// Optional build macro KEY_LOADER_ZEROIZE_EN: reset clears key_out, and
// an aborted load (entering DRAIN) wipes the shadow register.
module sdi_key_loader #(
    parameter int BUSW     = 32,
    parameter int KEYBYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUSW-1:0]       sdi_data,
    input  logic                  sdi_valid,
    output logic                  sdi_ready,
    input  logic                  key_lock,
    output logic [8*KEYBYTES-1:0] key_out,
    output logic                  key_valid,
    output logic                  key_update,
    output logic                  err
);

    import romulus_config_pkg::*;

    localparam int BPW       = BUSW / 8;
    localparam int FLD_WORDS = 4 / BPW;
    localparam int KEYBITS   = 8 * KEYBYTES;

    loader_state_t      state_reg, state_next;
    logic [1:0]         fld_cnt_reg, fld_cnt_next;
    logic [KEYBITS-1:0] shadow_reg, shadow_next, shadow_shift;
    logic [KEYBITS-1:0] key_reg, commit_key;
    logic               key_valid_reg, key_update_reg, err_reg, err_next;
    logic               commit, xfer, fld_last, fld_capture;
    logic               cnt_load, cnt_dec, cnt_last;
    logic [15:0]        cnt_load_bytes;
    logic [31:0]        fld_full;
    logic [3:0]         fld_nibble;
    logic [15:0]        fld_len;
    logic               unused_fld_bits;

    // Reset masks acceptance at once; otherwise only COMMIT stalls the bus.
    assign sdi_ready   = !rst && (state_reg != COMMIT);
    assign xfer        = sdi_valid && sdi_ready;
    assign fld_capture = xfer && ((state_reg == INSTR) || (state_reg == HDR));
    assign fld_last    = (fld_cnt_reg == 2'(FLD_WORDS - 1));

    // The 4-byte instruction/header field: the completed field is the
    // earlier words of this field followed by the current word.
    generate
        if (BUSW == 32) begin : g_fld_direct
            assign fld_full = sdi_data;
        end else begin : g_fld_shift
            logic [31-BUSW:0] fld_reg;
            assign fld_full = {fld_reg, sdi_data};
            // Hold the leading words of the field until its last word arrives.
            always_ff @(posedge clk) begin
                if (rst) begin
                    fld_reg <= '0;
                end else if (fld_capture) begin
                    fld_reg <= fld_full[31-BUSW:0];
                end
            end
        end

        if (KEYBITS > BUSW) begin : g_shadow_shift
            assign shadow_shift = {shadow_reg[KEYBITS-BUSW-1:0], sdi_data};
        end else begin : g_shadow_word
            assign shadow_shift = sdi_data;
        end
    endgenerate

    assign fld_nibble = fld_full[31:28];
    assign fld_len    = fld_full[15:0];
    // Instruction operand bits, header flags and header byte 1 carry nothing here.
    assign unused_fld_bits = ^fld_full[27:16];

    sdi_word_counter #(
        .BUSW (BUSW)
    ) u_word_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_bytes (cnt_load_bytes),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    // State, field position, shadow and status pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= INSTR;
            fld_cnt_reg    <= '0;
            shadow_reg     <= '0;
            key_valid_reg  <= 1'b0;
            key_update_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fld_cnt_reg    <= fld_cnt_next;
            shadow_reg     <= shadow_next;
            key_valid_reg  <= key_valid_reg || commit;
            key_update_reg <= commit;
            err_reg        <= err_next;
        end
    end

`ifdef KEY_LOADER_ZEROIZE_EN
    // Committed key: wiped by reset, otherwise only written on a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
        end else if (commit) begin
            key_reg <= commit_key;
        end
    end
`else
    // Committed key: plain datapath flops, written only on a commit.
    always_ff @(posedge clk) begin
        if (commit) begin
            key_reg <= commit_key;
        end
    end
`endif

    // Next-state, counter control, shadow update and commit decision.
    always_comb begin
        state_next     = state_reg;
        fld_cnt_next   = fld_cnt_reg;
        shadow_next    = shadow_reg;
        err_next       = 1'b0;
        commit         = 1'b0;
        commit_key     = shadow_reg;
        cnt_load       = 1'b0;
        cnt_load_bytes = '0;
        cnt_dec        = 1'b0;
        case (state_reg)
            INSTR, HDR: begin
                if (xfer) begin
                    if (!fld_last) begin
                        fld_cnt_next = fld_cnt_reg + 2'd1;
                    end else begin
                        fld_cnt_next = '0;
                        if (state_reg == INSTR) begin
                            if (fld_nibble == LDKEY) begin
                                state_next = HDR;
                            end else begin
                                err_next = 1'b1;
                            end
                        end else if ((fld_nibble == KEY) && (fld_len == 16'(KEYBYTES))) begin
                            state_next     = DATA;
                            cnt_load       = 1'b1;
                            cnt_load_bytes = 16'(KEYBYTES);
                        end else begin
                            err_next       = 1'b1;
                            cnt_load       = 1'b1;
                            cnt_load_bytes = fld_len;
                            if (fld_len == 16'd0) begin
                                state_next = INSTR;
                            end else begin
                                state_next = DRAIN;
`ifdef KEY_LOADER_ZEROIZE_EN
                                shadow_next = '0;
`endif
                            end
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shadow_next = shadow_shift;
                    cnt_dec     = 1'b1;
                    if (cnt_last) begin
                        if (!key_lock) begin
                            commit     = 1'b1;
                            commit_key = shadow_shift;
                            state_next = INSTR;
                        end else begin
                            state_next = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                if (!key_lock && !rst) begin
                    commit     = 1'b1;
                    state_next = INSTR;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_next = INSTR;
                    end
                end
            end
            default: begin
                state_next = INSTR;
            end
        endcase
    end

    assign key_out    = key_reg;
    assign key_valid  = key_valid_reg;
    assign key_update = key_update_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_sdi_key_loader.sv
// Self-checking bench for sdi_key_loader: a 32-bit and an 8-bit instance
// share clock and reset. Expected keys and event counts come from a
// byte-stream protocol parser kept in the bench.
module tb_sdi_key_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [31:0]  d32 = '0;
    logic         v32 = 1'b0, lock32 = 1'b0;
    logic         rdy32, kv32, ku32, err32;
    logic [127:0] key32;
    logic [7:0]   d8 = '0;
    logic         v8 = 1'b0, lock8 = 1'b0;
    logic         rdy8, kv8, ku8, err8;
    logic [127:0] key8;

    sdi_key_loader #(.BUSW(32), .KEYBYTES(16)) u32 (
        .clk(clk), .rst(rst), .sdi_data(d32), .sdi_valid(v32), .sdi_ready(rdy32),
        .key_lock(lock32), .key_out(key32), .key_valid(kv32), .key_update(ku32), .err(err32)
    );

    sdi_key_loader #(.BUSW(8), .KEYBYTES(16)) u8 (
        .clk(clk), .rst(rst), .sdi_data(d8), .sdi_valid(v8), .sdi_ready(rdy8),
        .key_lock(lock8), .key_out(key8), .key_valid(kv8), .key_update(ku8), .err(err8)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int upd32 = 0, errs32 = 0, xfers32 = 0, upd8 = 0, xfers8 = 0;

    // Event counters sampled at the active edge (values of the ending cycle).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ku32) upd32 <= upd32 + 1;
        if (err32) errs32 <= errs32 + 1;
        if (v32 && rdy32) xfers32 <= xfers32 + 1;
        if (ku8) upd8 <= upd8 + 1;
        if (v8 && rdy8) xfers8 <= xfers8 + 1;
    end

    logic [7:0]   stream[$];
    logic [127:0] model_key32;
    logic [127:0] model_key8;

    function automatic void stream_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endfunction

    function automatic void stream_load(input logic [127:0] k);
        stream_word({4'h4, 28'($urandom)});
        stream_word({4'hC, 4'($urandom), 8'h00, 16'd16});
        for (int j = 0; j < 4; j++) stream_word(k[127-32*j -: 32]);
    endfunction

    // Protocol parser over the byte stream: counts errors and commits and
    // returns the last complete key. bpw = bytes per bus word.
    function automatic void model_parse(input int bpw, inout logic [127:0] key,
                                        output int n_err, output int n_commit);
        int i = 0;
        int len;
        logic [7:0] b0;
        n_err = 0;
        n_commit = 0;
        while (i + 4 <= stream.size()) begin
            b0 = stream[i];
            i += 4;
            if (b0[7:4] != 4'h4) begin
                n_err++;
                continue;
            end
            if (i + 4 > stream.size()) break;
            b0 = stream[i];
            len = int'({stream[i+2], stream[i+3]});
            i += 4;
            if (b0[7:4] == 4'hC && len == 16) begin
                if (i + 16 > stream.size()) break;
                for (int j = 0; j < 16; j++) key = {key[119:0], stream[i+j]};
                i += 16;
                n_commit++;
            end else begin
                n_err++;
                i += ((len + bpw - 1) / bpw) * bpw;
            end
        end
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present stream word wi on the 32-bit bus and wait for its transfer edge.
    task automatic push32(input int wi);
        int n = 0;
        d32 = {stream[4*wi], stream[4*wi+1], stream[4*wi+2], stream[4*wi+3]};
        v32 = 1'b1;
        while (!rdy32 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy32) begin
            vectors++;
            miscompares++;
            $display("FAIL push32_timeout: sdi_ready=%b after %0d cycles, required 1", rdy32, n);
        end else begin
            @(negedge clk);
        end
        v32 = 1'b0;
    endtask

    // Present stream byte bi on the 8-bit bus after `gap` idle cycles.
    task automatic push8(input int bi, input int gap);
        int n = 0;
        v8 = 1'b0;
        repeat (gap) @(negedge clk);
        d8 = stream[bi];
        v8 = 1'b1;
        while (!rdy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) begin
            vectors++;
            miscompares++;
            $display("FAIL push8_timeout: sdi_ready=%b after %0d cycles, required 1", rdy8, n);
        end else begin
            @(negedge clk);
        end
        v8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (rdy32 !== 1'b0) begin miscompares++; $display("FAIL reset_ready32: got %b want 0", rdy32); end
        vectors++; if (kv32 !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid32: got %b want 0", kv32); end
        vectors++; if (ku32 !== 1'b0) begin miscompares++; $display("FAIL reset_key_update32: got %b want 0", ku32); end
        vectors++; if (err32 !== 1'b0) begin miscompares++; $display("FAIL reset_err32: got %b want 0", err32); end
        vectors++; if (rdy8 !== 1'b0) begin miscompares++; $display("FAIL reset_ready8: got %b want 0", rdy8); end
        vectors++; if (kv8 !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid8: got %b want 0", kv8); end
`ifdef KEY_LOADER_ZEROIZE_EN
        vectors++; if (key32 !== 128'd0) begin miscompares++; $display("FAIL reset_key32: got %h want 0", key32); end
`endif
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (rdy32 !== 1'b1) begin miscompares++; $display("FAIL idle_ready32: got %b want 1", rdy32); end
        vectors++; if (rdy8 !== 1'b1) begin miscompares++; $display("FAIL idle_ready8: got %b want 1", rdy8); end
    endtask

    task automatic test_basic_load();
        int ne, nc, c0, x0, u0, e0;
        stream.delete();
        stream_word(32'h40000000); stream_word(32'hC2000010);
        stream_word(32'h00010203); stream_word(32'h04050607);
        stream_word(32'h08090A0B); stream_word(32'h0C0D0E0F);
        model_parse(4, model_key32, ne, nc);
        c0 = cyc; x0 = xfers32; u0 = upd32; e0 = errs32;
        for (int w = 0; w < 6; w++) push32(w);
        vectors++; if (cyc - c0 != 6) begin miscompares++; $display("FAIL basic_cycles: got %0d want 6", cyc - c0); end
        vectors++; if (xfers32 - x0 != 6) begin miscompares++; $display("FAIL basic_xfers: got %0d want 6", xfers32 - x0); end
        vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL basic_key: got %h want %h", key32, model_key32); end
        vectors++; if (kv32 !== 1'b1) begin miscompares++; $display("FAIL basic_key_valid: got %b want 1", kv32); end
        repeat (3) @(negedge clk);
        vectors++; if (upd32 - u0 != nc) begin miscompares++; $display("FAIL basic_update_count: got %0d want %0d", upd32 - u0, nc); end
        vectors++; if (errs32 - e0 != ne) begin miscompares++; $display("FAIL basic_err_count: got %0d want %0d", errs32 - e0, ne); end
    endtask

    task automatic test_key_lock();
        int ne, nc, hold;
        logic [127:0] old_key;
        for (int it = 0; it < 3; it++) begin
            stream.delete();
            stream_load(rand_key());
            old_key = model_key32;
            model_parse(4, model_key32, ne, nc);
            hold = (it == 0) ? 5 : int'($urandom_range(1, 7));
            for (int w = 0; w < 5; w++) push32(w);
            lock32 = 1'b1;
            push32(5);
            for (int t = 0; t < hold; t++) begin
                vectors++; if (rdy32 !== 1'b0) begin miscompares++; $display("FAIL lock_ready: cycle %0d got %b want 0", t, rdy32); end
                vectors++; if (key32 !== old_key) begin miscompares++; $display("FAIL lock_key_held: got %h want %h", key32, old_key); end
                @(negedge clk);
            end
            lock32 = 1'b0;
            @(negedge clk);
            vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL lock_key: got %h want %h", key32, model_key32); end
            vectors++; if (ku32 !== 1'b1) begin miscompares++; $display("FAIL lock_update: got %b want 1", ku32); end
            @(negedge clk);
            vectors++; if (ku32 !== 1'b0) begin miscompares++; $display("FAIL lock_update_pulse: got %b want 0", ku32); end
        end
    endtask

    task automatic test_bad_opcode();
        int ne, nc, u0, e0;
        logic [3:0] op;
        for (int it = 0; it < 3; it++) begin
            stream.delete();
            op = (it == 0) ? 4'h7 : 4'($urandom);
            if (op == 4'h4) op = 4'h5;
            stream_word((it == 0) ? 32'h70000000 : {op, 28'($urandom)});
            stream_load(rand_key());
            model_parse(4, model_key32, ne, nc);
            u0 = upd32; e0 = errs32;
            push32(0);
            vectors++; if (err32 !== 1'b1) begin miscompares++; $display("FAIL opcode_err_pulse: op %h got %b want 1", op, err32); end
            for (int w = 1; w < 7; w++) push32(w);
            repeat (2) @(negedge clk);
            vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL opcode_key: got %h want %h", key32, model_key32); end
            vectors++; if (errs32 - e0 != ne) begin miscompares++; $display("FAIL opcode_err_count: got %0d want %0d", errs32 - e0, ne); end
            vectors++; if (upd32 - u0 != nc) begin miscompares++; $display("FAIL opcode_update_count: got %0d want %0d", upd32 - u0, nc); end
        end
    endtask

    task automatic test_bad_length();
        int ne, nc, u0, e0, len, nw;
        logic [3:0] typ;
        logic [127:0] old_key;
        for (int it = 0; it < 5; it++) begin
            stream.delete();
            typ = 4'hC;
            len = 8;
            if (it == 1) len = 0;
            if (it == 2) typ = 4'hD;
            if (it == 2) len = 16;
            if (it > 2) len = int'($urandom_range(17, 40));
            nw = (len + 3) / 4;
            stream_word({4'h4, 28'($urandom)});
            stream_word({typ, 4'($urandom), 8'h00, 16'(len)});
            for (int w = 0; w < nw; w++) stream_word($urandom);
            stream_load(rand_key());
            old_key = model_key32;
            model_parse(4, model_key32, ne, nc);
            u0 = upd32; e0 = errs32;
            push32(0);
            push32(1);
            vectors++; if (err32 !== 1'b1) begin miscompares++; $display("FAIL length_err_pulse: len %0d got %b want 1", len, err32); end
            for (int w = 0; w < nw; w++) push32(2 + w);
            vectors++; if (key32 !== old_key) begin miscompares++; $display("FAIL drain_key_held: got %h want %h", key32, old_key); end
            for (int w = 0; w < 6; w++) push32(2 + nw + w);
            repeat (2) @(negedge clk);
            vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL length_key: got %h want %h", key32, model_key32); end
            vectors++; if (errs32 - e0 != ne) begin miscompares++; $display("FAIL length_err_count: got %0d want %0d", errs32 - e0, ne); end
            vectors++; if (upd32 - u0 != nc) begin miscompares++; $display("FAIL length_update_count: got %0d want %0d", upd32 - u0, nc); end
        end
    endtask

    task automatic test_reset_mid_load();
        int ne, nc;
        logic [127:0] k;
        stream.delete();
        stream_load(rand_key());
        for (int w = 0; w < 4; w++) push32(w);
        rst = 1'b1;
        #1;
        vectors++; if (rdy32 !== 1'b0) begin miscompares++; $display("FAIL rst_cycle_ready: got %b want 0", rdy32); end
        @(negedge clk);
        rst = 1'b0;
`ifdef KEY_LOADER_ZEROIZE_EN
        model_key32 = '0;
`endif
        @(negedge clk);
        vectors++; if (kv32 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_key_valid: got %b want 0", kv32); end
        vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL rst_mid_key: got %h want %h", key32, model_key32); end
        stream.delete();
        k = rand_key();
        stream_load(k);
        model_parse(4, model_key32, ne, nc);
        for (int w = 0; w < 6; w++) push32(w);
        vectors++; if (key32 !== k) begin miscompares++; $display("FAIL rst_reload_key: got %h want %h", key32, k); end
        vectors++; if (kv32 !== 1'b1) begin miscompares++; $display("FAIL rst_reload_valid: got %b want 1", kv32); end
    endtask

    task automatic test_back_to_back();
        int ne, nc, c0, u0;
        stream.delete();
        stream_load(rand_key());
        stream_load(rand_key());
        model_parse(4, model_key32, ne, nc);
        c0 = cyc; u0 = upd32;
        for (int w = 0; w < 12; w++) push32(w);
        vectors++; if (cyc - c0 != 12) begin miscompares++; $display("FAIL b2b_cycles: got %0d want 12", cyc - c0); end
        vectors++; if (key32 !== model_key32) begin miscompares++; $display("FAIL b2b_key: got %h want %h", key32, model_key32); end
        repeat (2) @(negedge clk);
        vectors++; if (upd32 - u0 != nc) begin miscompares++; $display("FAIL b2b_update_count: got %0d want %0d", upd32 - u0, nc); end
    endtask

    task automatic test_bus8();
        int ne, nc, x0, u0;
        for (int it = 0; it < 3; it++) begin
            stream.delete();
            if (it == 0) begin
                stream_word(32'h40000000); stream_word(32'hC2000010);
                stream_word(32'h00010203); stream_word(32'h04050607);
                stream_word(32'h08090A0B); stream_word(32'h0C0D0E0F);
            end else begin
                stream_load(rand_key());
            end
            model_parse(1, model_key8, ne, nc);
            x0 = xfers8; u0 = upd8;
            for (int b = 0; b < 24; b++) push8(b, int'($urandom_range(0, 2)));
            repeat (2) @(negedge clk);
            vectors++; if (key8 !== model_key8) begin miscompares++; $display("FAIL bus8_key: got %h want %h", key8, model_key8); end
            vectors++; if (xfers8 - x0 != 24) begin miscompares++; $display("FAIL bus8_xfers: got %0d want 24", xfers8 - x0); end
            vectors++; if (upd8 - u0 != nc) begin miscompares++; $display("FAIL bus8_update_count: got %0d want %0d", upd8 - u0, nc); end
            vectors++; if (kv8 !== 1'b1) begin miscompares++; $display("FAIL bus8_key_valid: got %b want 1", kv8); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_key_lock();
        test_bad_opcode();
        test_bad_length();
        test_back_to_back();
        test_reset_mid_load();
        test_bus8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
